// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package inst_fetch_queue_pkg;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    // Instruction presented on an issue slot that holds no valid entry.
    localparam inst_t INST_NOP = 32'h0000_0000;

endpackage : inst_fetch_queue_pkg

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between IF (producer), the queue, and ID (consumer).
interface inst_fetch_queue_if #(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter int EXC_W   = 8
);
    logic                           flush;
    logic                           push_valid;
    logic [$clog2(FETCH_W+1)-1:0]   push_cnt;
    logic [31:0]                    push_pc;
    logic [FETCH_W*32-1:0]          push_inst;
    logic [EXC_W-1:0]               push_except;
    logic                           push_ready;
    logic [$clog2(ISSUE_W+1)-1:0]   pop_cnt;
    logic [ISSUE_W-1:0]             issue_valid;
    logic [ISSUE_W*32-1:0]          issue_pc;
    logic [ISSUE_W*32-1:0]          issue_inst;
    logic [ISSUE_W*EXC_W-1:0]       issue_except;
    logic [$clog2(DEPTH+1)-1:0]     count;

    // Fetch/decode side that drives the queue.
    modport master (
        output flush, push_valid, push_cnt, push_pc, push_inst, push_except, pop_cnt,
        input  push_ready, issue_valid, issue_pc, issue_inst, issue_except, count
    );

    // The queue itself.
    modport slave (
        input  flush, push_valid, push_cnt, push_pc, push_inst, push_except, pop_cnt,
        output push_ready, issue_valid, issue_pc, issue_inst, issue_except, count
    );
endinterface : inst_fetch_queue_if

// File: rtl/inst_fetch_queue.sv
// N-wide instruction queue between IF and ID. Accepts up to FETCH_W words per
// cycle, presents the ISSUE_W oldest entries, and drops everything on flush.
// Occupancy is tracked by an explicit counter; pointers only address storage.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter int EXC_W   = 8
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        inst_addr_t       pc;
        inst_t            inst;
        logic [EXC_W-1:0] except;
    } inst_queue_entry_t;

    // Flop storage: FETCH_W write ports, ISSUE_W read ports.
    inst_queue_entry_t r_mem [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_push_acc;
    logic [CW-1:0] w_push_n;
    logic [CW-1:0] w_issue_cnt;
    logic [CW-1:0] w_pop_req;
    logic [CW-1:0] w_pop_n;
    logic [PW-1:0] w_rd_idx [ISSUE_W];

    // Ready depends on registered occupancy only, never on this cycle's pop.
    assign bus.push_ready = ((CW'(DEPTH) - r_count) >= CW'(FETCH_W));
    assign bus.count      = r_count;

    // Accepted push/pop amounts; flush cancels both, oversize pops are clamped.
    always_comb begin
        w_push_acc  = bus.push_valid & bus.push_ready & ~bus.flush;
        w_push_n    = w_push_acc ? CW'(bus.push_cnt) : {CW{1'b0}};
        w_issue_cnt = (r_count > CW'(ISSUE_W)) ? CW'(ISSUE_W) : r_count;
        w_pop_req   = CW'(bus.pop_cnt);
        if (bus.flush) begin
            w_pop_n = {CW{1'b0}};
        end else if (w_pop_req > w_issue_cnt) begin
            w_pop_n = w_issue_cnt;
        end else begin
            w_pop_n = w_pop_req;
        end
    end

    // Head/tail/count update; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (bus.flush) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_head  <= r_head + PW'(w_pop_n);
            r_tail  <= r_tail + PW'(w_push_n);
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    // Write the accepted group contiguously from tail, wrapping modulo DEPTH.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (CW'(k) < w_push_n) begin
                r_mem[r_tail + PW'(k)] <= '{
                    pc:     bus.push_pc + 32'(4 * k),
                    inst:   bus.push_inst[32*k +: 32],
                    except: bus.push_except
                };
            end
        end
    end

    // Present the oldest entries; slots beyond occupancy read as zero/nop.
    always_comb begin
        bus.issue_valid  = {ISSUE_W{1'b0}};
        bus.issue_pc     = {(ISSUE_W*32){1'b0}};
        bus.issue_inst   = {(ISSUE_W*32){1'b0}};
        bus.issue_except = {(ISSUE_W*EXC_W){1'b0}};
        for (int i = 0; i < ISSUE_W; i++) begin
            w_rd_idx[i] = r_head + PW'(i);
            if (r_count > CW'(i)) begin
                bus.issue_valid[i]               = 1'b1;
                bus.issue_pc[32*i +: 32]         = r_mem[w_rd_idx[i]].pc;
                bus.issue_inst[32*i +: 32]       = r_mem[w_rd_idx[i]].inst;
                bus.issue_except[EXC_W*i +: EXC_W] = r_mem[w_rd_idx[i]].except;
            end else begin
                bus.issue_valid[i]               = 1'b0;
                bus.issue_pc[32*i +: 32]         = 32'h0000_0000;
                bus.issue_inst[32*i +: 32]       = INST_NOP;
                bus.issue_except[EXC_W*i +: EXC_W] = {EXC_W{1'b0}};
            end
        end
    end

endmodule : inst_fetch_queue

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (FETCH_W=2, ISSUE_W=2, DEPTH=8).
module tb_inst_fetch_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_queue_if #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8), .EXC_W(8)) ifc ();

    inst_fetch_queue #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8), .EXC_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  exc;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_head = 0;
    int   m_tail = 0;

    // ID must never consume more slots than are presented.
    always @(negedge clk) begin
        if (!rst) begin
            assert (int'(ifc.pop_cnt) <= $countones(ifc.issue_valid))
                else $error("pop_cnt exceeds presented slots");
        end
    end

    task automatic drive(input logic fl, input logic pv, input int pcnt,
                         input logic [31:0] base, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [7:0] exc, input int pop);
        ifc.flush       = fl;
        ifc.push_valid  = pv;
        ifc.push_cnt    = 2'(pcnt);
        ifc.push_pc     = base;
        ifc.push_inst   = {i1, i0};
        ifc.push_except = exc;
        ifc.pop_cnt     = 2'(pop);
    endtask

    // One clock: update the reference model with what was driven, then idle inputs.
    task automatic tick;
        bit   ready;
        ent_t e;
        ready = ((8 - sb.size()) >= 2);
        @(posedge clk);
        if (ifc.flush) begin
            sb.delete();
            m_head = 0;
            m_tail = 0;
        end else begin
            for (int k = 0; k < int'(ifc.pop_cnt); k++) void'(sb.pop_front());
            m_head = (m_head + int'(ifc.pop_cnt)) % 8;
            if (ifc.push_valid && ready) begin
                for (int k = 0; k < int'(ifc.push_cnt); k++) begin
                    e.pc   = ifc.push_pc + 32'(4 * k);
                    e.inst = ifc.push_inst[32*k +: 32];
                    e.exc  = ifc.push_except;
                    sb.push_back(e);
                end
                m_tail = (m_tail + int'(ifc.push_cnt)) % 8;
            end
        end
        #1;
        drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 0);
        #2;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ifc.count); end
        checks++; if (ifc.issue_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", ifc.issue_valid); end
        checks++; if (ifc.push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ifc.push_ready); end
        checks++; if (ifc.issue_inst !== 64'h0 || ifc.issue_pc !== 64'h0 || ifc.issue_except !== 16'h0) begin
            errors++; $display("FAIL reset_issue inst=%h pc=%h exc=%h want all 0", ifc.issue_inst, ifc.issue_pc, ifc.issue_except);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_push_pair;
        drive(1'b0, 1'b1, 2, 32'h100, 32'hAAAA_0001, 32'hBBBB_0002, 8'h00, 0);
        tick();
        checks++; if (ifc.count !== 4'd2) begin errors++; $display("FAIL pair_count got %0d want 2", ifc.count); end
        checks++; if (ifc.issue_valid !== 2'b11) begin errors++; $display("FAIL pair_valid got %b want 11", ifc.issue_valid); end
        checks++; if (ifc.issue_pc !== {32'h104, 32'h100}) begin errors++; $display("FAIL pair_pc got %h want 0000010400000100", ifc.issue_pc); end
        checks++; if (ifc.issue_inst !== {32'hBBBB_0002, 32'hAAAA_0001}) begin
            errors++; $display("FAIL pair_inst got %h want bbbb0002aaaa0001", ifc.issue_inst);
        end
    endtask

    task automatic test_push_pop;
        checks++; if (ifc.issue_pc[31:0] !== sb[0].pc || ifc.issue_inst[31:0] !== sb[0].inst) begin
            errors++; $display("FAIL consumed_slot0 got %h/%h want %h/%h", ifc.issue_pc[31:0], ifc.issue_inst[31:0], sb[0].pc, sb[0].inst);
        end
        drive(1'b0, 1'b1, 2, 32'h108, 32'hCCCC_0003, 32'hDDDD_0004, 8'h00, 1);
        tick();
        checks++; if (ifc.count !== 4'd3) begin errors++; $display("FAIL pushpop_count got %0d want 3", ifc.count); end
        checks++; if (ifc.issue_pc[31:0] !== 32'h104 || ifc.issue_inst[31:0] !== 32'hBBBB_0002) begin
            errors++; $display("FAIL pushpop_slot0 got %h@%h want bbbb0002@104", ifc.issue_inst[31:0], ifc.issue_pc[31:0]);
        end
        checks++; if (ifc.issue_pc[63:32] !== 32'h108 || ifc.issue_inst[63:32] !== 32'hCCCC_0003) begin
            errors++; $display("FAIL pushpop_slot1 got %h@%h want cccc0003@108", ifc.issue_inst[63:32], ifc.issue_pc[63:32]);
        end
    endtask

    task automatic test_full;
        drive(1'b0, 1'b1, 2, 32'h110, 32'hEEEE_0005, 32'hFFFF_0006, 8'h00, 0);
        tick();
        drive(1'b0, 1'b1, 2, 32'h118, 32'h1111_0007, 32'h2222_0008, 8'h00, 0);
        tick();
        checks++; if (ifc.count !== 4'd7) begin errors++; $display("FAIL full_count got %0d want 7", ifc.count); end
        checks++; if (ifc.push_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ifc.push_ready); end
        drive(1'b0, 1'b1, 2, 32'h120, 32'hDEAD_0009, 32'hDEAD_000A, 8'h00, 0);
        tick();
        checks++; if (ifc.count !== 4'd7) begin errors++; $display("FAIL ignored_push_count got %0d want 7", ifc.count); end
        checks++; if (ifc.issue_pc[31:0] !== sb[0].pc) begin errors++; $display("FAIL ignored_push_head got %h want %h", ifc.issue_pc[31:0], sb[0].pc); end
        drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 2);
        tick();
        checks++; if (ifc.count !== 4'd5) begin errors++; $display("FAIL drain_count got %0d want 5", ifc.count); end
        checks++; if (ifc.push_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b want 1", ifc.push_ready); end
    endtask

    task automatic test_wrap;
        logic [31:0] pc_next = 32'h120;
        bit          wrap_seen = 1'b0;
        int          pcnt;
        int          pop;
        for (int it = 0; it < 14; it++) begin
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (s < sb.size()) begin
                    if (ifc.issue_valid[s] !== 1'b1 || ifc.issue_pc[32*s +: 32] !== sb[s].pc || ifc.issue_inst[32*s +: 32] !== sb[s].inst) begin
                        errors++; $display("FAIL wrap_slot%0d it%0d got v=%b %h@%h want %h@%h", s, it, ifc.issue_valid[s],
                                           ifc.issue_inst[32*s +: 32], ifc.issue_pc[32*s +: 32], sb[s].inst, sb[s].pc);
                    end
                end else if (ifc.issue_valid[s] !== 1'b0 || ifc.issue_inst[32*s +: 32] !== 32'h0) begin
                    errors++; $display("FAIL wrap_empty_slot%0d it%0d got v=%b inst=%h want 0", s, it, ifc.issue_valid[s], ifc.issue_inst[32*s +: 32]);
                end
            end
            checks++; if (ifc.count !== 4'(sb.size())) begin errors++; $display("FAIL wrap_count it%0d got %0d want %0d", it, ifc.count, sb.size()); end
            if (m_head == 7 && sb.size() >= 2) begin
                wrap_seen = 1'b1;
                checks++; if (ifc.issue_pc[63:32] !== ifc.issue_pc[31:0] + 32'h4) begin
                    errors++; $display("FAIL wrap_contig got slot0 %h slot1 %h want slot1=slot0+4", ifc.issue_pc[31:0], ifc.issue_pc[63:32]);
                end
            end
            pcnt = (it == 0) ? 1 : 2;
            pop  = (sb.size() > 0) ? 1 : 0;
            if ((8 - sb.size()) >= 2) begin
                drive(1'b0, 1'b1, pcnt, pc_next, pc_next ^ 32'h5A00_0000, pc_next ^ 32'hA500_0004, 8'h00, pop);
                pc_next = pc_next + 32'(4 * pcnt);
            end else begin
                drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 8'h00, pop);
            end
            tick();
        end
        checks++; if (!wrap_seen) begin errors++; $display("FAIL wrap_reached got head-at-7 %b want 1", wrap_seen); end
        while (sb.size() > 4) begin
            drive(1'b0, 1'b0, 0, 32'h0, 32'h0, 32'h0, 8'h00, (sb.size() - 4 >= 2) ? 2 : 1);
            tick();
        end
        checks++; if (ifc.count !== 4'd4) begin errors++; $display("FAIL wrap_final_count got %0d want 4", ifc.count); end
    endtask

    task automatic test_flush;
        drive(1'b1, 1'b1, 2, 32'h300, 32'h3333_0001, 32'h3333_0002, 8'h00, 2);
        tick();
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", ifc.count); end
        checks++; if (ifc.issue_valid !== 2'b00 || ifc.issue_inst !== 64'h0) begin
            errors++; $display("FAIL flush_issue got v=%b inst=%h want 00/0", ifc.issue_valid, ifc.issue_inst);
        end
        tick();
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("FAIL flush_dropped got %0d want 0", ifc.count); end
    endtask

    task automatic test_except_and_async_reset;
        drive(1'b0, 1'b1, 1, 32'h200, 32'h4444_0001, 32'h0, 8'h11, 0);
        tick();
        drive(1'b0, 1'b1, 2, 32'h204, 32'h4444_0002, 32'h4444_0003, 8'h00, 0);
        tick();
        checks++; if (ifc.issue_except[7:0] !== 8'h11) begin errors++; $display("FAIL exc_slot0 got %h want 11", ifc.issue_except[7:0]); end
        checks++; if (ifc.issue_except[15:8] !== 8'h00) begin errors++; $display("FAIL exc_slot1 got %h want 00", ifc.issue_except[15:8]); end
        checks++; if (ifc.issue_pc !== {32'h204, 32'h200}) begin errors++; $display("FAIL exc_pc got %h want 0000020400000200", ifc.issue_pc); end
        drive(1'b0, 1'b1, 2, 32'h20C, 32'h4444_0004, 32'h4444_0005, 8'h00, 0);
        tick();
        checks++; if (ifc.count !== 4'd5) begin errors++; $display("FAIL pre_rst_count got %0d want 5", ifc.count); end
        rst = 1'b1;
        #2;
        checks++; if (ifc.count !== 4'd0 || ifc.issue_valid !== 2'b00 || ifc.push_ready !== 1'b1) begin
            errors++; $display("FAIL async_rst got count=%0d v=%b ready=%b want 0/00/1", ifc.count, ifc.issue_valid, ifc.push_ready);
        end
        checks++; if (ifc.issue_inst !== 64'h0 || ifc.issue_except !== 16'h0) begin
            errors++; $display("FAIL async_rst_issue got inst=%h exc=%h want 0", ifc.issue_inst, ifc.issue_except);
        end
        sb.delete();
        m_head = 0;
        m_tail = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push_pair();
        test_push_pop();
        test_full();
        test_wrap();
        test_flush();
        test_except_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_inst_fetch_queue
